// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with load/start/pause control and a one-second prescaler.
// Counts down while running and playing_condition is high; flags expiry with a level and a one-cycle strobe.
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [4:0]  load_minutes,
    input  logic [5:0]  load_seconds,
    input  logic        start,
    input  logic        pause,
    input  logic        playing_condition,
    output logic [10:0] timer,
    output logic [5:0]  seconds,
    output logic [4:0]  minutes,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned TW = 11;
    localparam int unsigned SW = 6;
    localparam int unsigned MW = 5;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [MW-1:0] MAX_MIN    = MW'(30);
    localparam logic [SW-1:0] MAX_SEC    = SW'(59);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          pulse_q, pulse_d;

    logic [MW-1:0] load_min_c;
    logic [SW-1:0] load_sec_c;
    logic          tick_c;

    // Clamp the requested start value; a full 30 minutes carries no extra seconds.
    always_comb begin
        load_min_c = (load_minutes > MAX_MIN) ? MAX_MIN : load_minutes;
        load_sec_c = (load_seconds > MAX_SEC) ? MAX_SEC : load_seconds;
        if (load_min_c == MAX_MIN) begin
            load_sec_c = '0;
        end
    end

    assign tick_c = (state_q == RUNNING) && playing_condition && (presc_q == PRESC_LAST);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        timer_d = timer_q;
        sec_d   = sec_q;
        min_d   = min_q;
        pulse_d = 1'b0;

        if (load && (state_q != RUNNING)) begin
            state_d = IDLE;
            presc_d = '0;
            min_d   = load_min_c;
            sec_d   = load_sec_c;
            timer_d = TW'(load_min_c) * TW'(60) + TW'(load_sec_c);
        end else if (pause && (state_q == RUNNING)) begin
            state_d = PAUSED;
        end else if (start && ((state_q == IDLE) || (state_q == PAUSED)) && (timer_q != '0)) begin
            state_d = RUNNING;
        end else if ((state_q == RUNNING) && playing_condition) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c && (timer_q != '0)) begin
                timer_d = timer_q - TW'(1);
                if (sec_q == '0) begin
                    sec_d = MAX_SEC;
                    min_d = min_q - MW'(1);
                end else begin
                    sec_d = sec_q - SW'(1);
                end
                if (timer_q == TW'(1)) begin
                    state_d = EXPIRED;
                    pulse_d = 1'b1;
                end
            end
        end

        running_d = (state_d == RUNNING);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            timer_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            timer_q   <= timer_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            running_q <= running_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
        end
    end

    assign timer         = timer_q;
    assign seconds       = sec_q;
    assign minutes       = min_q;
    assign running       = running_q;
    assign expired       = expired_q;
    assign expired_pulse = pulse_q;

endmodule
